// File: rtl/ctrl_decode_pipe.sv
// RV64I/RV32I control decoder registered at the ID/EX boundary.
// Handles valid/ready handshakes, load-use bubble insertion and a saturating stall count.
module ctrl_decode_pipe #(
  parameter int XLEN       = 64,
  parameter int MASK_W     = XLEN/8,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ALUsrc,
  output logic [2:0]        ALUOp,
  output logic [1:0]        memtoreg,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              bra,
  output logic              bne,
  output logic              jump,
  output logic              jalr,
  output logic              reg_wr,
  output logic              sd,
  output logic              ld,
  output logic [MASK_W-1:0] wmask,
  output logic              illegal,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_ADDI = 3'd6;

  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_COND  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  typedef struct packed {
    logic              alusrc;
    logic [2:0]        aluop;
    logic [1:0]        memtoreg;
    logic              mem_wr, mem_rd, bra, bne, jump, jalr, reg_wr, sd, ld;
    logic [MASK_W-1:0] wmask;
    logic              illegal;
    logic [4:0]        rd, rs1, rs2;
  } ctrl_t;

  ctrl_t      dec, q;
  logic [6:0] opc, f7;
  logic [2:0] f3, lop;
  logic       lop_ok, bad, rd_rs2, hazard;
  logic [0:0] state;
  logic [1:0] cnt;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Logical/compare ops share funct3 encoding between ARITH and OP-IMM.
  always_comb begin
    lop_ok = 1'b1;
    case (f3)
      3'b111:  lop = ALU_AND;
      3'b110:  lop = ALU_OR;
      3'b100:  lop = ALU_XOR;
      3'b010:  lop = ALU_SLT;
      default: begin lop = ALU_ADD; lop_ok = 1'b0; end
    endcase
  end

  always_comb begin
    dec = '0;
    dec.aluop = ALU_ADD;
    bad = 1'b0;
    rd_rs2 = 1'b0;
    case (opc)
      OP_ARITH: begin
        dec.reg_wr = 1'b1;
        rd_rs2 = 1'b1;
        if (f3 == 3'b000 && f7 == 7'b0000000)      dec.aluop = ALU_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) dec.aluop = ALU_SUB;
        else if (f3 != 3'b000 && f7 == 7'b0000000 && lop_ok) dec.aluop = lop;
        else bad = 1'b1;
      end
      OP_IMM: begin
        dec.alusrc = 1'b1;
        dec.reg_wr = 1'b1;
        if (f3 == 3'b000) dec.aluop = ALU_ADDI;
        else if (lop_ok)  dec.aluop = lop;
        else bad = 1'b1;
      end
      OP_COND: begin
        dec.bra = 1'b1;
        dec.bne = (f3 == 3'b001);
        rd_rs2 = 1'b1;
        bad = (f3[2:1] != 2'b00);
      end
      OP_JAL, OP_JALR: begin
        dec.jump = 1'b1;
        dec.reg_wr = 1'b1;
        dec.memtoreg = 2'b10;
        dec.jalr = (opc == OP_JALR);
        dec.alusrc = (opc == OP_JALR);
      end
      OP_LOAD: begin
        dec.ld = 1'b1;
        dec.mem_rd = 1'b1;
        dec.alusrc = 1'b1;
        dec.aluop = ALU_ADDI;
        dec.memtoreg = 2'b01;
        dec.reg_wr = 1'b1;
      end
      OP_STORE: begin
        dec.sd = 1'b1;
        dec.mem_wr = 1'b1;
        dec.alusrc = 1'b1;
        dec.aluop = ALU_ADDI;
        rd_rs2 = 1'b1;
        case (f3)
          3'b000:  dec.wmask = MASK_W'(1);
          3'b001:  dec.wmask = MASK_W'(3);
          3'b010:  dec.wmask = MASK_W'(15);
          3'b011:  if (XLEN == 64) dec.wmask = '1; else bad = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings become a NOP bundle that still travels down the pipe.
    if (bad) begin
      dec = '0;
      dec.aluop = ALU_ADD;
      dec.illegal = 1'b1;
    end
    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
  end

  assign hazard = in_valid && out_valid && q.ld && (q.rd != 5'd0) &&
                  ((dec.rs1 == q.rd) || (rd_rs2 && dec.rs2 == q.rd));

  assign in_ready = !flush && (state == RUN) && !hazard && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      q.aluop   <= ALU_ADD;
      state     <= RUN;
      cnt       <= 2'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= RUN;
      cnt       <= 2'd0;
    end else begin
      if (in_valid && in_ready) begin
        q         <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // The draining cycle of the load is itself the first bubble.
      if (state == BUBBLE) begin
        if (cnt == 2'd0) state <= RUN;
        else             cnt   <= cnt - 2'd1;
      end else if (hazard && out_ready && LU_BUBBLES > 1) begin
        state <= BUBBLE;
        cnt   <= 2'(LU_BUBBLES - 2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign ALUsrc   = q.alusrc;
  assign ALUOp    = q.aluop;
  assign memtoreg = q.memtoreg;
  assign mem_wr   = q.mem_wr;
  assign mem_rd   = q.mem_rd;
  assign bra      = q.bra;
  assign bne      = q.bne;
  assign jump     = q.jump;
  assign jalr     = q.jalr;
  assign reg_wr   = q.reg_wr;
  assign sd       = q.sd;
  assign ld       = q.ld;
  assign wmask    = q.wmask;
  assign illegal  = q.illegal;
  assign rd       = q.rd;
  assign rs1      = q.rs1;
  assign rs2      = q.rs2;

endmodule
